uart_tx_port: RTL

Memory-mapped serial transmitter on the processor's shared data bus, alongside `ram`, `user_input` and `video_controller`. It sits downstream of the processor: system glue decodes `address_reg` into `write`/`read` strobes, the same way the existing peripherals are selected. Bytes written by software are buffered in a small FIFO and shifted out on `tx` as 8N1 frames. A status word can be read back over the same bidirectional bus.

---
 rtl/uart_tx_port.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - bus-mapped 8N1 serial transmitter with byte FIFO and status registers
module uart_tx_port #(
  parameter int CLOCKS_PER_BIT  = 4,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  inout  wire  [31:0] data,
  output logic        tx,
  output logic        busy
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [15:0] BAUD_LAST = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // FIFO storage and bookkeeping
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       push_req;
  logic                       push;
  logic                       pop;
  logic                       overflow;
  logic                       status_read;

  // Transmit engine
  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        baud_done;
  logic        frame_active;
  logic        tx_reg;

  // Bus read path
  logic [31:0] read_data;
  logic        unused_bits;

  // Upper bus bits carry nothing for TXDATA writes.
  assign unused_bits = ^data[31:8];

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == COUNT_FULL);
  assign push_req     = write && (address == ADDR_TXDATA);
  // Full is judged on occupancy before the edge, so a same-edge pop never rescues a push.
  assign push         = push_req && !fifo_full;
  assign status_read  = read && (address == ADDR_STATUS);
  assign baud_done    = (baud_cnt == BAUD_LAST);
  assign frame_active = (state != ST_IDLE);
  assign busy         = !fifo_empty || frame_active;
  assign tx           = tx_reg;

  // Pop request: IDLE grabs a byte at once, STOP grabs one at the end of the stop bit.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = !fifo_empty;
      ST_STOP: pop = baud_done && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO data array; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at their width.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a rejected push wins over the clear-on-read.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end else if (status_read) begin
      overflow <= 1'b0;
    end
  end

  // Frame sequencer; tx is registered so each level is held for a whole bit period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= ST_START;
            tx_reg    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= ST_DATA;
            tx_reg   <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state  <= ST_STOP;
              tx_reg <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              // Next byte starts immediately so back-to-back frames have no idle gap.
              shift_reg <= mem[rd_ptr];
              bit_cnt   <= '0;
              state     <= ST_START;
              tx_reg    <= 1'b0;
            end else begin
              state  <= ST_IDLE;
              tx_reg <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

  // Register read mux; TXDATA and the reserved offset read as zero.
  always_comb begin
    read_data = '0;
    case (address)
      ADDR_STATUS: read_data[3:0] = {overflow, frame_active, fifo_full, fifo_empty};
      ADDR_COUNT:  read_data[FIFO_DEPTH_LOG2:0] = count;
      default:     read_data = '0;
    endcase
  end

  assign data = read ? read_data : 32'bz;

endmodule
